pll_pfd_lock: RTL and testbench
===============================

Name: pll_pfd_lock

Overview:
- Digital phase-frequency detector with lock monitor. Sits directly downstream of the feedback frequency divider in the PLL-SERDES loop.
- Compares the divided feedback clock against the reference clock, both oversampled by the fast system clock `clk`.
- Produces UP/DN correction levels for the loop filter, a signed per-cycle phase-error word, a cycle-slip flag and a `locked` indication.

Parameters:
- ERR_W, 8, width of signed phase_err; magnitude saturates at 2^(ERR_W-1)-1.
- LOCK_TOL, 2, max |phase_err| in clk cycles counted as in-tolerance.
- LOCK_CNT, 8, consecutive in-tolerance measurements required to assert locked; 1..255.

Ports:
- clk  input  1  oversampling system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ref_in  input  1  reference clock, asynchronous to clk.
- fb_in  input  1  divided feedback clock from the frequency divider, asynchronous to clk.
- up  output  1  high while ref leads fb.
- dn  output  1  high while fb leads ref.
- phase_err  output  ERR_W  signed error; +N means ref led by N clk cycles.
- err_valid  output  1  one-cycle strobe when phase_err updates.
- slip  output  1  one-cycle strobe on a cycle slip.
- locked  output  1  lock indication.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, FSM in IDLE, counters 0, synchronizers 0.
- Input capture: ref_in and fb_in each pass through a 2-flop synchronizer plus a third delay flop. A rise is sync2 & ~sync3, a one-cycle pulse.
- Latency: `up`/`dn` assert on the 3rd clk edge after the first edge that samples the input high.
- FSM states: IDLE, LEAD_REF, LEAD_FB. up = (state==LEAD_REF); dn = (state==LEAD_FB); both registered.
- IDLE, ref_rise only: go to LEAD_REF, cnt <= 1.
- IDLE, fb_rise only: go to LEAD_FB, cnt <= 1.
- IDLE, both rises same cycle: stay IDLE; phase_err <= 0; err_valid pulse.
- LEAD_REF, no fb_rise: cnt increments each cycle, saturating at 2^(ERR_W-1)-1.
- LEAD_REF, fb_rise: go to IDLE; phase_err <= +cnt; err_valid pulse.
- LEAD_REF, fb_rise and ref_rise in the same cycle: the fb_rise closes the measurement as above, then the new ref_rise opens LEAD_REF with cnt <= 1 (return to IDLE is skipped).
- LEAD_REF, ref_rise without fb_rise (cycle slip): stay in LEAD_REF; cnt <= 1; slip pulse; no err_valid.
- LEAD_FB: mirror of LEAD_REF with signs inverted (phase_err <= -cnt).
- phase_err holds its value between err_valid strobes.
- Lock monitor, on each err_valid:
  - |err| <= LOCK_TOL: lock_cnt increments, saturating at LOCK_CNT; locked <= 1 when lock_cnt reaches LOCK_CNT.
  - Otherwise: lock_cnt <= 0, locked <= 0.
- Any slip pulse: lock_cnt <= 0, locked <= 0, same cycle as slip.
- locked changes only on the clock edge after the qualifying event.
- Reset mid-measurement: the pending error is discarded; no err_valid after reset release until a full new edge pair.

Optional Feature:
- Macro: PLL_PFD_LOCK_HYST_EN.
- Defined: unlock requires 2 consecutive out-of-tolerance measurements. A single excursion only clears lock_cnt while locked stays 1. A slip still unlocks immediately.
- Undefined: a single out-of-tolerance measurement deasserts locked, as in Behaviour.

Test Plan:
- Reset: hold rst_n low, toggle both inputs -> all outputs 0. Release -> up=dn=0 until the first rise.
- ref rise, fb rise 5 clk later (clean, synchronous to clk) -> up high exactly 5 cycles, dn=0, phase_err=+5, err_valid one cycle.
- fb leads ref by 3 clk -> dn high 3 cycles, phase_err=-3 (0xFD with ERR_W=8).
- Both rise same cycle -> up=dn=0, phase_err=0, err_valid one cycle.
- Lock sequence: 8 pairs with |err|<=2 -> locked rises after the 8th err_valid. Then one pair with err=+4 -> locked falls, or with PLL_PFD_LOCK_HYST_EN stays 1 until a 2nd out-of-tolerance pair.
- Two ref rises, no fb, then fb far beyond range:
  - 2nd ref rise gives a slip pulse, locked=0, cnt restarts at 1.
  - A 200-cycle lead saturates: phase_err=+127.
  - rst_n pulse mid-lead returns to IDLE with no err_valid.

Source files
------------

// File: rtl/pll_pfd_lock.sv
// Oversampled phase-frequency detector: UP/DN levels, signed phase error, cycle-slip strobe, lock monitor.
// Optional PLL_PFD_LOCK_HYST_EN: unlock needs two consecutive out-of-tolerance measurements.
module pll_pfd_lock #(
   parameter int ERR_W    = 8,
   parameter int LOCK_TOL = 2,
   parameter int LOCK_CNT = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ref_in,
   input  logic                    fb_in,
   output logic                    up,
   output logic                    dn,
   output logic signed [ERR_W-1:0] phase_err,
   output logic                    err_valid,
   output logic                    slip,
   output logic                    locked
);
   localparam int CW = ERR_W - 1;
   localparam logic [CW-1:0]    CNT_MAX  = '1;
   localparam logic [7:0]       LOCK_MAX = 8'(LOCK_CNT);
   localparam logic [ERR_W-1:0] TOL      = ERR_W'(LOCK_TOL);

   typedef enum logic [1:0] {IDLE, LEAD_REF, LEAD_FB} state_t;
   state_t state, state_nxt;

   logic [2:0]              ref_sync, fb_sync;
   logic                    ref_rise, fb_rise;
   logic [CW-1:0]           cnt, cnt_nxt, cnt_inc;
   logic signed [ERR_W-1:0] cnt_pos, err_nxt;
   logic                    ev_nxt, slip_nxt;
   logic [ERR_W-1:0]        err_mag;
   logic                    in_tol;
   logic [7:0]              lock_cnt, lock_inc;
`ifdef PLL_PFD_LOCK_HYST_EN
   logic                    miss;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_sync <= '0;
         fb_sync  <= '0;
      end else begin
         ref_sync <= {ref_sync[1:0], ref_in};
         fb_sync  <= {fb_sync[1:0], fb_in};
      end
   end

   assign ref_rise = ref_sync[1] & ~ref_sync[2];
   assign fb_rise  = fb_sync[1] & ~fb_sync[2];
   assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
   assign cnt_pos  = $signed({1'b0, cnt});

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      err_nxt   = phase_err;
      ev_nxt    = 1'b0;
      slip_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (ref_rise && fb_rise) begin
               ev_nxt  = 1'b1;
               err_nxt = '0;
            end else if (ref_rise) begin
               state_nxt = LEAD_REF;
               cnt_nxt   = CW'(1);
            end else if (fb_rise) begin
               state_nxt = LEAD_FB;
               cnt_nxt   = CW'(1);
            end
         end
         LEAD_REF: begin
            // A coincident ref rise reopens the next measurement without visiting IDLE
            if (fb_rise) begin
               ev_nxt  = 1'b1;
               err_nxt = cnt_pos;
               if (ref_rise) cnt_nxt = CW'(1);
               else          state_nxt = IDLE;
            end else if (ref_rise) begin
               slip_nxt = 1'b1;
               cnt_nxt  = CW'(1);
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         LEAD_FB: begin
            if (ref_rise) begin
               ev_nxt  = 1'b1;
               err_nxt = -cnt_pos;
               if (fb_rise) cnt_nxt = CW'(1);
               else         state_nxt = IDLE;
            end else if (fb_rise) begin
               slip_nxt = 1'b1;
               cnt_nxt  = CW'(1);
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         up        <= 1'b0;
         dn        <= 1'b0;
         phase_err <= '0;
         err_valid <= 1'b0;
         slip      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         up        <= (state == LEAD_REF);
         dn        <= (state == LEAD_FB);
         phase_err <= err_nxt;
         err_valid <= ev_nxt;
         slip      <= slip_nxt;
      end
   end

   assign err_mag  = phase_err[ERR_W-1] ? $unsigned(-phase_err) : $unsigned(phase_err);
   assign in_tol   = (err_mag <= TOL);
   assign lock_inc = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 1'b1;

   // Lock monitor judges the registered error the cycle after its strobe; a slip wins outright
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
`ifdef PLL_PFD_LOCK_HYST_EN
         miss     <= 1'b0;
`endif
      end else if (slip_nxt) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
`ifdef PLL_PFD_LOCK_HYST_EN
         miss     <= 1'b0;
`endif
      end else if (err_valid) begin
         if (in_tol) begin
            lock_cnt <= lock_inc;
            if (lock_inc == LOCK_MAX) locked <= 1'b1;
`ifdef PLL_PFD_LOCK_HYST_EN
            miss     <= 1'b0;
`endif
         end else begin
            lock_cnt <= '0;
`ifdef PLL_PFD_LOCK_HYST_EN
            if (locked && !miss) begin
               miss <= 1'b1;
            end else begin
               miss   <= 1'b0;
               locked <= 1'b0;
            end
`else
            locked   <= 1'b0;
`endif
         end
      end
   end
endmodule

// File: tb/tb_pll_pfd_lock.sv
// Bench for pll_pfd_lock: random pulse trains scored against a timestamp-based reference model.
module tb_pll_pfd_lock;
   localparam int ERR_W    = 8;
   localparam int LOCK_TOL = 2;
   localparam int LOCK_CNT = 8;
   localparam int ERR_MAX  = (1 << (ERR_W - 1)) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ref_in = 1'b0;
   logic fb_in = 1'b0;
   logic up, dn, err_valid, slip, locked;
   logic signed [ERR_W-1:0] phase_err;

   int checks = 0;
   int errors = 0;

   // Reference model: who leads and since which step, plus run lengths of good/bad measurements
   bit rh[4];
   bit fh[4];
   int lead, lead_start, kstep;
   bit m_up, m_dn, m_ev, m_slip, m_locked, prev_ev;
   int m_err, prev_err, good_run, bad_run;
   int obs_up, obs_dn, obs_ev, obs_slip;
   int r_at[8];
   int f_at[8];

   pll_pfd_lock #(.ERR_W(ERR_W), .LOCK_TOL(LOCK_TOL), .LOCK_CNT(LOCK_CNT)) dut (
      .clk(clk), .rst_n(rst_n), .ref_in(ref_in), .fb_in(fb_in),
      .up(up), .dn(dn), .phase_err(phase_err), .err_valid(err_valid),
      .slip(slip), .locked(locked)
   );

   always #5 clk = ~clk;

   function automatic int sat(input int v);
      return (v > ERR_MAX) ? ERR_MAX : v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         rh[i] = 1'b0;
         fh[i] = 1'b0;
      end
      lead = 0; lead_start = 0;
      m_up = 0; m_dn = 0; m_ev = 0; m_slip = 0; m_locked = 0; prev_ev = 0;
      m_err = 0; prev_err = 0; good_run = 0; bad_run = 0;
   endtask

   task automatic model_edge(input bit r, input bit f);
      bit rr, fr;
      int a;
      for (int i = 3; i > 0; i--) begin
         rh[i] = rh[i-1];
         fh[i] = fh[i-1];
      end
      rh[0] = r;
      fh[0] = f;
      kstep++;
      rr = rh[2] && !rh[3];
      fr = fh[2] && !fh[3];
      if (prev_ev) begin
         a = (prev_err < 0) ? -prev_err : prev_err;
         if (a <= LOCK_TOL) begin good_run++; bad_run = 0; end
         else begin good_run = 0; bad_run++; end
`ifdef PLL_PFD_LOCK_HYST_EN
         m_locked = (good_run >= LOCK_CNT) || (m_locked && bad_run < 2);
`else
         m_locked = (good_run >= LOCK_CNT);
`endif
      end
      m_up = (lead == 1);
      m_dn = (lead == 2);
      m_ev = 0;
      m_slip = 0;
      if (rr && fr) begin
         m_ev = 1;
         if (lead == 0) m_err = 0;
         else begin
            m_err = (lead == 1) ? sat(kstep - lead_start) : -sat(kstep - lead_start);
            lead_start = kstep;
         end
      end else if (rr) begin
         if (lead == 1) begin m_slip = 1; lead_start = kstep; end
         else if (lead == 2) begin m_ev = 1; m_err = -sat(kstep - lead_start); lead = 0; end
         else begin lead = 1; lead_start = kstep; end
      end else if (fr) begin
         if (lead == 2) begin m_slip = 1; lead_start = kstep; end
         else if (lead == 1) begin m_ev = 1; m_err = sat(kstep - lead_start); lead = 0; end
         else begin lead = 2; lead_start = kstep; end
      end
      if (m_slip) begin good_run = 0; bad_run = 0; m_locked = 0; end
      prev_ev = m_ev;
      prev_err = m_err;
   endtask

   task automatic step(input bit r, input bit f);
      @(negedge clk);
      ref_in = r;
      fb_in = f;
      @(posedge clk);
      model_edge(r, f);
      #1;
      obs_up += int'(up); obs_dn += int'(dn);
      obs_ev += int'(err_valid); obs_slip += int'(slip);
      checks++; if (up !== m_up) begin errors++; $display("FAIL up step %0d: got %b want %b", kstep, up, m_up); end
      checks++; if (dn !== m_dn) begin errors++; $display("FAIL dn step %0d: got %b want %b", kstep, dn, m_dn); end
      checks++; if (err_valid !== m_ev) begin errors++; $display("FAIL err_valid step %0d: got %b want %b", kstep, err_valid, m_ev); end
      checks++; if (slip !== m_slip) begin errors++; $display("FAIL slip step %0d: got %b want %b", kstep, slip, m_slip); end
      checks++; if (locked !== m_locked) begin errors++; $display("FAIL locked step %0d: got %b want %b", kstep, locked, m_locked); end
      checks++; if (phase_err !== m_err[ERR_W-1:0]) begin errors++; $display("FAIL phase_err step %0d: got %0d want %0d", kstep, phase_err, m_err); end
   endtask

   task automatic run_pattern(input int nr, input int nf, input int len);
      bit r, f;
      obs_up = 0; obs_dn = 0; obs_ev = 0; obs_slip = 0;
      for (int s = 0; s < len; s++) begin
         r = 0;
         f = 0;
         for (int i = 0; i < nr; i++) if (s >= r_at[i] && s < r_at[i] + 2) r = 1;
         for (int i = 0; i < nf; i++) if (s >= f_at[i] && s < f_at[i] + 2) f = 1;
         step(r, f);
      end
   endtask

   // d > 0: ref leads by d; d < 0: fb leads by -d; d == 0: coincident
   task automatic pair(input int d);
      r_at[0] = (d < 0) ? -d : 0;
      f_at[0] = (d > 0) ? d : 0;
      run_pattern(1, 1, ((d < 0) ? -d : d) + 8);
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({up, dn, err_valid, slip, locked, phase_err} !== '0) begin
         errors++; $display("FAIL reset_async: got %b want 0", {up, dn, err_valid, slip, locked, phase_err});
      end
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         ref_in = 1'($urandom);
         fb_in = 1'($urandom);
         @(posedge clk);
         #1;
         checks++;
         if ({up, dn, err_valid, slip, locked, phase_err} !== '0) begin
            errors++; $display("FAIL reset_hold: got %b want 0", {up, dn, err_valid, slip, locked, phase_err});
         end
      end
      @(negedge clk);
      ref_in = 1'b0;
      fb_in = 1'b0;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset(6);
      run_pattern(0, 0, 5);
      checks++; if (obs_up + obs_dn != 0) begin errors++; $display("FAIL idle_after_reset: up+dn cycles %0d want 0", obs_up + obs_dn); end
   endtask

   task automatic test_ref_lead();
      pair(5);
      checks++; if (obs_up != 5) begin errors++; $display("FAIL ref_lead_up_cycles: got %0d want 5", obs_up); end
      checks++; if (obs_dn != 0) begin errors++; $display("FAIL ref_lead_dn_cycles: got %0d want 0", obs_dn); end
      checks++; if (obs_ev != 1) begin errors++; $display("FAIL ref_lead_strobes: got %0d want 1", obs_ev); end
      checks++; if (phase_err !== 8'h05) begin errors++; $display("FAIL ref_lead_err: got %h want 05", phase_err); end
   endtask

   task automatic test_fb_lead();
      pair(-3);
      checks++; if (obs_dn != 3) begin errors++; $display("FAIL fb_lead_dn_cycles: got %0d want 3", obs_dn); end
      checks++; if (obs_ev != 1) begin errors++; $display("FAIL fb_lead_strobes: got %0d want 1", obs_ev); end
      checks++; if (phase_err !== 8'hFD) begin errors++; $display("FAIL fb_lead_err: got %h want fd", phase_err); end
   endtask

   task automatic test_simultaneous();
      pair(0);
      checks++; if (obs_up + obs_dn != 0) begin errors++; $display("FAIL simul_updn: got %0d want 0", obs_up + obs_dn); end
      checks++; if (obs_ev != 1) begin errors++; $display("FAIL simul_strobes: got %0d want 1", obs_ev); end
      checks++; if (phase_err !== 8'h00) begin errors++; $display("FAIL simul_err: got %h want 00", phase_err); end
   endtask

   task automatic test_lock();
      bit exp;
      do_reset(2);
      for (int i = 0; i < 8; i++) begin
         pair(int'($urandom_range(0, 4)) - 2);
         exp = (i == 7);
         checks++; if (locked !== exp) begin errors++; $display("FAIL lock_pair%0d: got %b want %b", i, locked, exp); end
      end
      pair(4);
`ifdef PLL_PFD_LOCK_HYST_EN
      exp = 1'b1;
`else
      exp = 1'b0;
`endif
      checks++; if (locked !== exp) begin errors++; $display("FAIL lock_excursion1: got %b want %b", locked, exp); end
      pair(-4);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_excursion2: got %b want 0", locked); end
   endtask

   task automatic test_back_to_back();
      r_at[0] = 0; r_at[1] = 6;
      f_at[0] = 6; f_at[1] = 9;
      run_pattern(2, 2, 16);
      checks++; if (obs_ev != 2) begin errors++; $display("FAIL b2b_strobes: got %0d want 2", obs_ev); end
      checks++; if (obs_slip != 0) begin errors++; $display("FAIL b2b_slip: got %0d want 0", obs_slip); end
      checks++; if (obs_up != 9) begin errors++; $display("FAIL b2b_up_cycles: got %0d want 9", obs_up); end
      checks++; if (phase_err !== 8'h03) begin errors++; $display("FAIL b2b_err: got %h want 03", phase_err); end
   endtask

   task automatic test_slip();
      do_reset(2);
      for (int i = 0; i < 8; i++) pair(1);
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL slip_prelock: got %b want 1", locked); end
      r_at[0] = 0; r_at[1] = 10; f_at[0] = 15;
      run_pattern(2, 1, 24);
      checks++; if (obs_slip != 1) begin errors++; $display("FAIL slip_count: got %0d want 1", obs_slip); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL slip_unlock: got %b want 0", locked); end
      checks++; if (phase_err !== 8'h05) begin errors++; $display("FAIL slip_restart_err: got %h want 05", phase_err); end
      r_at[0] = 0; f_at[0] = 200;
      run_pattern(1, 1, 208);
      checks++; if (phase_err !== 8'h7F) begin errors++; $display("FAIL saturate_err: got %h want 7f", phase_err); end
      checks++; if (obs_up != ERR_MAX && obs_up != 200) begin errors++; $display("FAIL saturate_up_cycles: got %0d want 200", obs_up); end
   endtask

   task automatic test_reset_mid_lead();
      r_at[0] = 0;
      run_pattern(1, 0, 20);
      checks++; if (up !== 1'b1) begin errors++; $display("FAIL midlead_up: got %b want 1", up); end
      do_reset(2);
      f_at[0] = 3;
      run_pattern(0, 1, 10);
      checks++; if (obs_ev != 0) begin errors++; $display("FAIL midlead_strobes: got %0d want 0", obs_ev); end
      checks++; if (obs_dn != 4) begin errors++; $display("FAIL midlead_dn_cycles: got %0d want 4", obs_dn); end
   endtask

   task automatic test_random();
      int tr, tf;
      for (int round = 0; round < 8; round++) begin
         tr = int'($urandom_range(0, 5));
         tf = int'($urandom_range(0, 5));
         for (int i = 0; i < 8; i++) begin
            r_at[i] = tr;
            f_at[i] = tf;
            tr += int'($urandom_range(3, 14));
            tf += int'($urandom_range(3, 14));
         end
         run_pattern(8, 8, ((tr > tf) ? tr : tf) + 8);
      end
   endtask

   initial begin
      kstep = 0;
      model_reset();
      test_reset();
      test_ref_lead();
      test_fb_lead();
      test_simultaneous();
      test_lock();
      test_back_to_back();
      test_slip();
      test_reset_mid_lead();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
